ifetch_resp_buffer: RTL and testbench



---
 rtl/ifetch_resp_buffer.sv | 192 +++++++++++++++++++
 tb/tb_ifetch_resp_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_resp_buffer.sv
// ifetch_resp_buffer: consumer end of the instruction-ROM fetch path.
// Each accepted fetch request gets a tag {valid, pc, epoch}. The tag moves
// through a LATENCY-stage pipeline that stays aligned with the ROM read
// latency, so the tag and its ROM word arrive together. Responses whose epoch
// matches the current epoch are buffered in a DEPTH-entry FIFO for decode.
// Responses with a stale epoch, left over from before a redirect, are dropped.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clk_en           global enable; when low, all state holds
//   flush            redirect: kills in-flight and buffered words
//   req_valid/req_pc fetch request from the PC generator
//   req_ready        credit available: (inflight + occupancy) < DEPTH
//   rom_data         ROM word, valid LATENCY enabled cycles after its request
//   out_valid/out_pc/out_instr/out_ready  instruction handshake to decode
//
// Optional feature macro: IFB_BYPASS_EN. When it is defined and the FIFO is
// empty, a matching response is presented to decode combinationally in its
// arrival cycle. When it is undefined, every word passes through the FIFO
// first, and there is no combinational path from rom_data to the outputs.

package core_config_pkg;
  localparam int unsigned IF_LATENCY = 2;
endpackage

module ifetch_resp_buffer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = core_config_pkg::IF_LATENCY,
  parameter int unsigned DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_pc,
  output logic            req_ready,
  input  logic [XLEN-1:0] rom_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IFL_W = $clog2(LATENCY + 1);
  // A tag lives at most LATENCY cycles, so LATENCY+2 epoch values ensure that
  // back-to-back flushes never alias a survivor onto the current epoch.
  localparam int unsigned EP_W  = $clog2(LATENCY + 2);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned LAST  = LATENCY - 1;

  // Tag pipeline.
  logic            tag_vld_q [LATENCY];
  logic            tag_vld_d [LATENCY];
  logic [XLEN-1:0] tag_pc_q  [LATENCY];
  logic [XLEN-1:0] tag_pc_d  [LATENCY];
  logic [EP_W-1:0] tag_ep_q  [LATENCY];
  logic [EP_W-1:0] tag_ep_d  [LATENCY];

  // Response FIFO.
  logic [XLEN-1:0]  fifo_pc_q    [DEPTH];
  logic [XLEN-1:0]  fifo_pc_d    [DEPTH];
  logic [XLEN-1:0]  fifo_instr_q [DEPTH];
  logic [XLEN-1:0]  fifo_instr_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IFL_W-1:0] inflight_q, inflight_d;
  logic [EP_W-1:0]  epoch_q, epoch_d;

  logic flush_en, req_acc, resp_vld, resp_hit, fifo_empty;
  logic byp, byp_take, push, pop;

  // Handshake and control decode. All of it comes from registered state plus
  // the current-cycle inputs.
  always_comb begin
    flush_en   = clk_en & flush;
    fifo_empty = (count_q == '0);
    req_ready  = (SUM_W'(inflight_q) + SUM_W'(count_q)) < SUM_W'(DEPTH);
    req_acc    = clk_en & req_valid & req_ready;
    resp_vld   = tag_vld_q[LAST];
    resp_hit   = resp_vld & (tag_ep_q[LAST] == epoch_q);
`ifdef IFB_BYPASS_EN
    byp        = clk_en & resp_hit & fifo_empty & ~flush_en;
`else
    byp        = 1'b0;
`endif
    byp_take   = byp & out_ready;
    // A flush hides the head in its own cycle, so a concurrent out_ready does nothing.
    out_valid  = ~flush_en & (~fifo_empty | byp);
    pop        = clk_en & ~flush_en & ~fifo_empty & out_ready;
    // A response in the flush cycle still carries the pre-flush epoch, so it is masked here.
    push       = clk_en & ~flush_en & resp_hit & ~byp_take;
  end

`ifdef IFB_BYPASS_EN
  assign out_pc    = byp ? tag_pc_q[LAST] : fifo_pc_q[rd_ptr_q];
  assign out_instr = byp ? rom_data       : fifo_instr_q[rd_ptr_q];
`else
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_instr = fifo_instr_q[rd_ptr_q];
`endif

  // Next state. Nothing advances while clk_en is low.
  always_comb begin
    epoch_d      = epoch_q;
    inflight_d   = inflight_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_vld_d    = tag_vld_q;
    tag_pc_d     = tag_pc_q;
    tag_ep_d     = tag_ep_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (clk_en) begin
      if (flush) begin
        epoch_d = EP_W'(epoch_q + 1'b1);
      end

      for (int i = LAST; i > 0; i--) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_pc_d[i]  = tag_pc_q[i-1];
        tag_ep_d[i]  = tag_ep_q[i-1];
      end
      // A request issued together with a flush is tagged with the new epoch.
      tag_vld_d[0] = req_acc;
      tag_pc_d[0]  = req_pc;
      tag_ep_d[0]  = epoch_d;

      // Stale tags keep their credit until they leave the last stage.
      inflight_d = IFL_W'(inflight_q + IFL_W'(req_acc) - IFL_W'(resp_vld));

      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          fifo_pc_d[wr_ptr_q]    = tag_pc_q[LAST];
          fifo_instr_d[wr_ptr_q] = rom_data;
          wr_ptr_d               = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop) begin
          rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (push && !pop) begin
          count_d = CNT_W'(count_q + 1'b1);
        end else if (pop && !push) begin
          count_d = CNT_W'(count_q - 1'b1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q    <= '{default: 1'b0};
      tag_pc_q     <= '{default: '0};
      tag_ep_q     <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      epoch_q      <= '0;
    end else begin
      tag_vld_q    <= tag_vld_d;
      tag_pc_q     <= tag_pc_d;
      tag_ep_q     <= tag_ep_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      epoch_q      <= epoch_d;
    end
  end

  // The credit rule makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CNT_W'(DEPTH))))
    else $error("ifetch_resp_buffer: push into full FIFO");

endmodule

// File: tb/tb_ifetch_resp_buffer.sv
// Directed testbench for ifetch_resp_buffer (LATENCY=2, DEPTH=4, default build).
// The ROM model returns (pc << 5) + 0x13, LATENCY enabled cycles after the address.
// Each vector drives its inputs 1 time unit after posedge and checks 1 unit later.

module tb_ifetch_resp_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic [31:0] rom_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  logic [31:0] rom_a0 = 32'h0;
  logic [31:0] rom_a1 = 32'h0;
  logic        rom_ovr = 1'b0;
  logic [31:0] rom_ovr_val = 32'h0;

  int tests_run    = 0;
  int tests_failed = 0;

  ifetch_resp_buffer #(
    .XLEN    (32),
    .LATENCY (2),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .flush     (flush),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .req_ready (req_ready),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Two-stage ROM that holds while clk_en is low.
  always @(posedge clk) begin
    if (clk_en) begin
      rom_a0 <= req_pc;
      rom_a1 <= rom_a0;
    end
  end
  assign rom_data = rom_ovr ? rom_ovr_val : ((rom_a1 << 5) + 32'h13);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_pc = 32'h0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc",    out_pc,         32'h0);
    check("rst_out_instr", out_instr,      32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    #1 rst_n = 1'b1;
    cyc();

    // Streaming: first out_valid three cycles after the first request.
    out_ready = 1'b1; req_valid = 1'b1; req_pc = 32'h00; #1;
    check("s_rdy0", 32'(req_ready), 32'h1);
    cyc(); req_pc = 32'h04; #1;
    check("s_ov_c1", 32'(out_valid), 32'h0);
    cyc(); req_pc = 32'h08; #1;
    check("s_ov_c2", 32'(out_valid), 32'h0);
    cyc(); req_valid = 1'b0; #1;
    check("s_ov_c3", 32'(out_valid), 32'h1);
    check("s_pc0",   out_pc,    32'h00);
    check("s_in0",   out_instr, 32'h13);
    cyc(); #1;
    check("s_pc1",   out_pc,    32'h04);
    check("s_in1",   out_instr, 32'h93);
    cyc(); #1;
    check("s_pc2",   out_pc,    32'h08);
    check("s_in2",   out_instr, 32'h113);
    cyc(); #1;
    check("s_ov_end", 32'(out_valid), 32'h0);
    check("s_rdy_end", 32'(req_ready), 32'h1);

    // Back-pressure: only four credits, then drain in order.
    out_ready = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_pc = (k < 4) ? 32'h20 + 32'(4 * k) : 32'h30;
      #1;
      check($sformatf("bp_rdy%0d", k), 32'(req_ready), (k < 4) ? 32'h1 : 32'h0);
      if (k == 7) begin
        check("bp_full_ov", 32'(out_valid), 32'h1);
        check("bp_full_pc", out_pc, 32'h20);
      end
      cyc();
    end
    req_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("dr_ov%0d", k), 32'(out_valid), 32'h1);
      check($sformatf("dr_pc%0d", k), out_pc, 32'h20 + 32'(4 * k));
      check($sformatf("dr_in%0d", k), out_instr, 32'h413 + 32'(32'h80 * k));
      check($sformatf("dr_rdy%0d", k), 32'(req_ready), (k == 0) ? 32'h0 : 32'h1);
      cyc();
    end
    #1;
    check("dr_empty", 32'(out_valid), 32'h0);

    // Flush mid-flight: two buffered, two in flight. The redirect request waits for credit.
    out_ready = 1'b0;
    cyc();
    req_valid = 1'b1; req_pc = 32'h40; cyc();
    req_pc = 32'h44; cyc();
    req_pc = 32'h48; cyc();
    req_pc = 32'h4C; #1;
    check("fl_rdy_c3", 32'(req_ready), 32'h1);
    cyc();
    flush = 1'b1; req_pc = 32'h100; out_ready = 1'b1; #1;
    check("fl_ov_flush", 32'(out_valid), 32'h0);
    check("fl_rdy_flush", 32'(req_ready), 32'h0);
    cyc();
    flush = 1'b0; #1;
    check("fl_ov_c5", 32'(out_valid), 32'h0);
    check("fl_rdy_c5", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 1'b0; #1;
    check("fl_ov_c6", 32'(out_valid), 32'h0);
    cyc(); #1;
    check("fl_ov_c7", 32'(out_valid), 32'h0);
    cyc(); #1;
    check("fl_ov_c8", 32'(out_valid), 32'h1);
    check("fl_pc",    out_pc,    32'h100);
    check("fl_in",    out_instr, 32'h2013);
    cyc(); #1;
    check("fl_ov_c9", 32'(out_valid), 32'h0);

    // Double flush: only the request issued with the second flush survives.
    cyc();
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h200; #1;
    check("df_rdy0", 32'(req_ready), 32'h1);
    cyc();
    req_pc = 32'h204; #1;
    check("df_rdy1", 32'(req_ready), 32'h1);
    cyc();
    flush = 1'b0; req_valid = 1'b0; #1;
    check("df_ov_c2", 32'(out_valid), 32'h0);
    cyc(); #1;
    check("df_ov_c3", 32'(out_valid), 32'h0);
    cyc(); #1;
    check("df_ov_c4", 32'(out_valid), 32'h1);
    check("df_pc",    out_pc,    32'h204);
    check("df_in",    out_instr, 32'h4093);
    cyc(); #1;
    check("df_ov_c5", 32'(out_valid), 32'h0);

    // clk_en gating: three disabled cycles freeze the head and the tag pipeline.
    cyc();
    req_valid = 1'b1; req_pc = 32'h300; cyc();
    req_pc = 32'h304; cyc();
    req_valid = 1'b0; #1;
    check("ce_ov_c2", 32'(out_valid), 32'h0);
    cyc();
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("ce_hold_ov%0d", k), 32'(out_valid), 32'h1);
      check($sformatf("ce_hold_pc%0d", k), out_pc, 32'h300);
      check($sformatf("ce_hold_rdy%0d", k), 32'(req_ready), 32'h1);
      cyc();
    end
    clk_en = 1'b1; #1;
    check("ce_pc_c6", out_pc,    32'h300);
    check("ce_in_c6", out_instr, 32'h6013);
    cyc(); #1;
    check("ce_ov_c7", 32'(out_valid), 32'h1);
    check("ce_pc_c7", out_pc,    32'h304);
    check("ce_in_c7", out_instr, 32'h6093);
    cyc(); #1;
    check("ce_ov_c8", 32'(out_valid), 32'h0);

    // Async reset with three words buffered.
    out_ready = 1'b0;
    cyc();
    req_valid = 1'b1; req_pc = 32'h400; cyc();
    req_pc = 32'h404; cyc();
    req_pc = 32'h408; cyc();
    req_valid = 1'b0; cyc();
    cyc(); #1;
    check("ar_pre_ov", 32'(out_valid), 32'h1);
    check("ar_pre_pc", out_pc, 32'h400);
    #2 rst_n = 1'b0; #1;
    check("ar_ov",  32'(out_valid), 32'h0);
    check("ar_rdy", 32'(req_ready), 32'h1);
    check("ar_pc",  out_pc, 32'h0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1; rom_ovr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      rom_ovr_val = (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678; #1;
      check($sformatf("ar_post_ov%0d", k), 32'(out_valid), 32'h0);
    end
    rom_ovr = 1'b0;

    // Normal operation resumes after reset.
    cyc();
    req_valid = 1'b1; req_pc = 32'h500; cyc();
    req_valid = 1'b0; cyc();
    cyc(); #1;
    check("ar_new_ov", 32'(out_valid), 32'h1);
    check("ar_new_pc", out_pc,    32'h500);
    check("ar_new_in", out_instr, 32'hA013);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
